// File: rtl/dft_requant_pkg.sv
// Shared widths, sample/state types and the round/saturate arithmetic
// used by the DFT output requantiser.
package dft_requant_pkg;

    localparam int IN_W  = 30;
    localparam int OUT_W = 16;
    localparam int PTS_W = 12;
    localparam int SH_W  = 5;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } frame_state_e;

    typedef struct packed {
        logic signed [IN_W-1:0] re;
        logic signed [IN_W-1:0] im;
        logic                   sop;
        logic                   eop;
    } sample_t;

    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

    // One guard bit keeps x + 2^(sh-1) from overflowing before the shift.
    function automatic logic signed [IN_W:0] round_shift(
        input logic signed [IN_W-1:0] x,
        input logic [SH_W-1:0]        sh
    );
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] bias;
        ext  = {x[IN_W-1], x};
        bias = '0;
        if (sh != '0) begin
            bias = (IN_W+1)'(1) << (sh - SH_W'(1));
        end
        return (ext + bias) >>> sh;
    endfunction

    function automatic logic is_sat(input logic signed [IN_W:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end
        if (v < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return v[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_round(
        input logic signed [IN_W-1:0] x,
        input logic [SH_W-1:0]        sh
    );
        return saturate(round_shift(x, sh));
    endfunction

endpackage

// File: rtl/dft_out_requant_if.sv
// Sample stream bundle (valid/ready, framing, complex data, frame length).
interface dft_out_requant_if #(
    parameter int DW = dft_requant_pkg::IN_W,
    parameter int PW = dft_requant_pkg::PTS_W
);
    logic                 valid;
    logic                 ready;
    logic                 sop;
    logic                 eop;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [PW-1:0]        pts;

    modport master (
        output valid, sop, eop, re, im, pts,
        input  ready
    );

    modport slave (
        input  valid, sop, eop, re, im, pts,
        output ready
    );
endinterface

// File: rtl/dft_requant_lane.sv
// One component lane: S1 rounds and shifts, S2 saturates into the output register.
module dft_requant_lane
    import dft_requant_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s1_en,
    input  logic                    s2_en,
    input  logic signed [IN_W-1:0]  x,
    input  logic [SH_W-1:0]         sh,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    logic signed [IN_W:0]    r_p1_q, r_p1_d;
    logic signed [OUT_W-1:0] y_p2_q, y_p2_d;
    logic                    sat_p2_q, sat_p2_d;

    // S1: round-half-up and arithmetic shift
    always_comb begin
        r_p1_d = r_p1_q;
        if (s1_en) begin
            r_p1_d = round_shift(x, sh);
        end
    end

    always_ff @(posedge clk) begin
        r_p1_q <= r_p1_d;
    end

    // S2: saturate into the output register (held while stalled)
    always_comb begin
        y_p2_d   = y_p2_q;
        sat_p2_d = sat_p2_q;
        if (s2_en) begin
            y_p2_d   = saturate(r_p1_q);
            sat_p2_d = is_sat(r_p1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p2_q   <= '0;
            sat_p2_q <= 1'b0;
        end else begin
            y_p2_q   <= y_p2_d;
            sat_p2_q <= sat_p2_d;
        end
    end

    assign y   = y_p2_q;
    assign sat = sat_p2_q;

endmodule

// File: rtl/dft_out_requant.sv
// Requantises the DFT source stream to OUT_W bits through an elastic 2-stage
// pipeline, checks frame length and reports per-frame saturation count.
module dft_out_requant
    import dft_requant_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    dft_out_requant_if.slave   snk,
    dft_out_requant_if.master  src,
    input  logic [SH_W-1:0]    shift_in,
    output logic [PTS_W-1:0]   sat_cnt,
    output logic               sat_cnt_valid,
    output logic               frame_err
);

    frame_state_e     state_q, state_d;
    logic [PTS_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [PTS_W-1:0] pts_q, pts_d, pts_eff;
    logic [SH_W-1:0]  sh_q, sh_d, sh_eff;
    logic             frame_err_q, frame_err_d;
    logic             fwd, err;

    logic             s1_adv, s2_adv, accept, s1_load, s2_load, out_fire;
    logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic             sop_p1_q, sop_p1_d, eop_p1_q, eop_p1_d;
    logic [PTS_W-1:0] pts_p1_q, pts_p1_d;
    logic             sop_p2_q, sop_p2_d, eop_p2_q, eop_p2_d;
    logic [PTS_W-1:0] pts_p2_q, pts_p2_d;

    logic [PTS_W-1:0] sat_acc_q, sat_acc_d, sat_base;
    logic [PTS_W-1:0] sat_cnt_q, sat_cnt_d;
    logic             sat_cnt_valid_q, sat_cnt_valid_d;
    logic             sat_re, sat_im;
    logic signed [OUT_W-1:0] y_re, y_im;
    sample_t          in_s;

    assign in_s = '{re: snk.re, im: snk.im, sop: snk.sop, eop: snk.eop};

    always_comb begin
        s2_adv   = !vld_p2_q || src.ready;
        s1_adv   = !vld_p1_q || s2_adv;
        accept   = snk.valid && s1_adv;
        s1_load  = accept && fwd;
        s2_load  = s2_adv && vld_p1_q;
        out_fire = vld_p2_q && src.ready;
        vld_p1_d = s1_adv ? s1_load : vld_p1_q;
        vld_p2_d = s2_adv ? vld_p1_q : vld_p2_q;
    end

    assign snk.ready = s1_adv;

    // The sop beat uses its own shift/length; later beats use the latched copy.
    always_comb begin
        sh_eff  = sh_q;
        pts_eff = pts_q;
        if (in_s.sop) begin
            sh_eff  = (shift_in > SH_W'(IN_W-1)) ? SH_W'(IN_W-1) : shift_in;
            pts_eff = snk.pts;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        pts_d   = pts_q;
        fwd     = 1'b0;
        err     = 1'b0;
        cnt_inc = cnt_q + PTS_W'(1);
        if (accept) begin
            if (in_s.sop) begin
                fwd   = 1'b1;
                sh_d  = sh_eff;
                pts_d = pts_eff;
                err   = (state_q == IN_FRAME);
                if (in_s.eop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (snk.pts != PTS_W'(1)) begin
                        err = 1'b1;
                    end
                end else begin
                    state_d = IN_FRAME;
                    cnt_d   = PTS_W'(1);
                end
            end else if (state_q == IDLE) begin
                err = 1'b1;
            end else begin
                fwd   = 1'b1;
                cnt_d = cnt_inc;
                if (in_s.eop) begin
                    state_d = IDLE;
                    err     = (cnt_inc != pts_q);
                end else if (cnt_inc == '1) begin
                    // Runaway frame: abandon it without inventing an eop.
                    state_d = IDLE;
                    err     = 1'b1;
                end
            end
        end
        frame_err_d = err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            pts_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            pts_q       <= pts_d;
            frame_err_q <= frame_err_d;
        end
    end

    // S1 framing sideband, qualified by vld_p1
    always_comb begin
        sop_p1_d = sop_p1_q;
        eop_p1_d = eop_p1_q;
        pts_p1_d = pts_p1_q;
        if (s1_load) begin
            sop_p1_d = in_s.sop;
            eop_p1_d = in_s.eop;
            pts_p1_d = pts_eff;
        end
    end

    always_ff @(posedge clk) begin
        sop_p1_q <= sop_p1_d;
        eop_p1_q <= eop_p1_d;
        pts_p1_q <= pts_p1_d;
    end

    // S2 output registers and saturation bookkeeping
    always_comb begin
        sop_p2_d = sop_p2_q;
        eop_p2_d = eop_p2_q;
        pts_p2_d = pts_p2_q;
        if (s2_load) begin
            sop_p2_d = sop_p1_q;
            eop_p2_d = eop_p1_q;
            pts_p2_d = pts_p1_q;
        end
        sat_base        = sop_p2_q ? '0 : sat_acc_q;
        sat_acc_d       = sat_acc_q;
        sat_cnt_d       = sat_cnt_q;
        sat_cnt_valid_d = 1'b0;
        if (out_fire) begin
            sat_acc_d = sat_base + PTS_W'(sat_re || sat_im);
            if (eop_p2_q) begin
                sat_cnt_d       = sat_acc_d;
                sat_cnt_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q        <= 1'b0;
            vld_p2_q        <= 1'b0;
            sop_p2_q        <= 1'b0;
            eop_p2_q        <= 1'b0;
            pts_p2_q        <= '0;
            sat_acc_q       <= '0;
            sat_cnt_q       <= '0;
            sat_cnt_valid_q <= 1'b0;
        end else begin
            vld_p1_q        <= vld_p1_d;
            vld_p2_q        <= vld_p2_d;
            sop_p2_q        <= sop_p2_d;
            eop_p2_q        <= eop_p2_d;
            pts_p2_q        <= pts_p2_d;
            sat_acc_q       <= sat_acc_d;
            sat_cnt_q       <= sat_cnt_d;
            sat_cnt_valid_q <= sat_cnt_valid_d;
        end
    end

    dft_requant_lane u_lane_re (
        .clk   (clk),
        .rst_n (rst_n),
        .s1_en (s1_load),
        .s2_en (s2_load),
        .x     (in_s.re),
        .sh    (sh_eff),
        .y     (y_re),
        .sat   (sat_re)
    );

    dft_requant_lane u_lane_im (
        .clk   (clk),
        .rst_n (rst_n),
        .s1_en (s1_load),
        .s2_en (s2_load),
        .x     (in_s.im),
        .sh    (sh_eff),
        .y     (y_im),
        .sat   (sat_im)
    );

    assign src.valid     = vld_p2_q;
    assign src.sop       = sop_p2_q;
    assign src.eop       = eop_p2_q;
    assign src.re        = y_re;
    assign src.im        = y_im;
    assign src.pts       = pts_p2_q;
    assign sat_cnt       = sat_cnt_q;
    assign sat_cnt_valid = sat_cnt_valid_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_dft_out_requant.sv
// Directed-vector bench for dft_out_requant with a queue scoreboard and a
// separate output monitor.
module tb_dft_out_requant;
    import dft_requant_pkg::*;

    typedef struct {
        int re;
        int im;
        bit sop;
        bit eop;
        int pts;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SH_W-1:0]  shift_in;
    logic [PTS_W-1:0] sat_cnt;
    logic             sat_cnt_valid;
    logic             frame_err;

    dft_out_requant_if #(.DW(IN_W),  .PW(PTS_W)) snk_if ();
    dft_out_requant_if #(.DW(OUT_W), .PW(PTS_W)) src_if ();

    dft_out_requant dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .snk           (snk_if),
        .src           (src_if),
        .shift_in      (shift_in),
        .sat_cnt       (sat_cnt),
        .sat_cnt_valid (sat_cnt_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_ferr = 0;
    int   n_satv = 0;
    int   last_sat = -1;
    int   sop_acc_cyc = 0;
    int   sop_out_cyc = 0;
    bit   bp_mode = 1'b0;
    int   bp_idx = 0;
    logic [3:0] bp_pat = 4'b1001;

    always @(posedge clk) cyc <= cyc + 1;

    initial src_if.ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            src_if.ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end else begin
            src_if.ready = 1'b1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: a transfer seen at the falling edge happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (src_if.valid && !src_if.ready && exp_q.size() >= 2)
                check("stall_sink_ready", int'(snk_if.ready), 0);
            if (src_if.valid && src_if.ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: got re=%0d im=%0d, none expected",
                             int'(src_if.re), int'(src_if.im));
                end else begin
                    e = exp_q.pop_front();
                    if (int'(src_if.re) != e.re || int'(src_if.im) != e.im ||
                        src_if.sop != e.sop || src_if.eop != e.eop ||
                        (e.sop && int'(src_if.pts) != e.pts)) begin
                        n_bad++;
                        $display("FAIL beat: got re=%0d im=%0d sop=%0d eop=%0d pts=%0d expected re=%0d im=%0d sop=%0d eop=%0d pts=%0d",
                                 int'(src_if.re), int'(src_if.im), src_if.sop, src_if.eop, int'(src_if.pts),
                                 e.re, e.im, e.sop, e.eop, e.pts);
                    end
                    if (src_if.sop) sop_out_cyc = cyc;
                end
            end
            if (frame_err) n_ferr++;
            if (sat_cnt_valid) begin
                n_satv++;
                last_sat = int'(sat_cnt);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic sop, input logic eop, input int pts, input logic [SH_W-1:0] sh,
                        input int re, input int im, input logic fwd, input int ere, input int eim);
        int  guard;
        bit  taken;
        guard = 0;
        taken = 1'b0;
        snk_if.valid = 1'b1;
        snk_if.sop   = sop;
        snk_if.eop   = eop;
        snk_if.pts   = PTS_W'(pts);
        snk_if.re    = IN_W'(re);
        snk_if.im    = IN_W'(im);
        shift_in     = sh;
        while (!taken) begin
            @(negedge clk);
            if (snk_if.ready) taken = 1'b1;
            else if (++guard > 50) break;
        end
        if (!taken) check("sink_ready_timeout", 0, 1);
        if (taken && sop) sop_acc_cyc = cyc;
        @(posedge clk);
        if (taken && fwd) exp_q.push_back('{re: ere, im: eim, sop: sop, eop: eop, pts: pts});
        #1;
        snk_if.valid = 1'b0;
        snk_if.sop   = 1'b0;
        snk_if.eop   = 1'b0;
    endtask

    task automatic ramp(input int pts, input int n);
        for (int k = 0; k < n; k++)
            send(k == 0, k == pts - 1, pts, SH_W'(14), 16384 * k, 16384 * k, 1'b1, k, k);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_ctrl_outs", int'({src_if.valid, src_if.sop, src_if.eop, sat_cnt_valid, frame_err}), 0);
        check("rst_re_im", int'(src_if.re) | int'(src_if.im), 0);
        check("rst_pts_satcnt", int'(src_if.pts) | int'(sat_cnt), 0);
    endtask

    initial begin
        int ferr0, satv0;
        snk_if.valid = 1'b0;
        snk_if.sop   = 1'b0;
        snk_if.eop   = 1'b0;
        snk_if.pts   = '0;
        snk_if.re    = '0;
        snk_if.im    = '0;
        shift_in     = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1200-point ramp, shift 14, full throughput
        ferr0 = n_ferr; satv0 = n_satv;
        ramp(1200, 1200);
        drain();
        check("t1_latency", sop_out_cyc - sop_acc_cyc, 2);
        check("t1_frame_err", n_ferr - ferr0, 0);
        check("t1_satv_pulses", n_satv - satv0, 1);
        check("t1_sat_cnt", last_sat, 0);

        // Rounding at shift 4
        send(1, 0, 4, SH_W'(4),  8,  8, 1,  1,  1);
        send(0, 0, 4, SH_W'(4),  7,  7, 1,  0,  0);
        send(0, 0, 4, SH_W'(4), -8, -8, 1,  0,  0);
        send(0, 1, 4, SH_W'(4), -9, -9, 1, -1, -1);
        drain();

        // Saturation at shift 0, one component clipping per sample
        ferr0 = n_ferr; satv0 = n_satv;
        send(1, 0, 12, SH_W'(0), 40000, 5, 1, 32767, 5);
        send(0, 0, 12, SH_W'(0), 1, -40000, 1, 1, -32768);
        send(0, 0, 12, SH_W'(0), 32767, -32768, 1, 32767, -32768);
        for (int k = 3; k < 12; k++)
            send(0, k == 11, 12, SH_W'(0), 100 * k, -100 * k, 1, 100 * k, -100 * k);
        drain();
        check("t3_satv_pulses", n_satv - satv0, 1);
        check("t3_sat_cnt", last_sat, 2);
        check("t3_frame_err", n_ferr - ferr0, 0);

        // Back-pressure with ready pattern 1,0,0,1
        ferr0 = n_ferr; satv0 = n_satv;
        bp_mode = 1'b1;
        ramp(1200, 1200);
        drain();
        bp_mode = 1'b0;
        check("t4_frame_err", n_ferr - ferr0, 0);
        check("t4_satv_pulses", n_satv - satv0, 1);
        check("t4_sat_cnt", last_sat, 0);

        // Short frame: eop on the 7th sample of an 8-point frame
        ferr0 = n_ferr;
        for (int k = 0; k < 7; k++)
            send(k == 0, k == 6, 8, SH_W'(0), k, -k, 1, k, -k);
        drain();
        check("t5_short_frame_err", n_ferr - ferr0, 1);

        // sop in mid-frame restarts and the new frame is forwarded
        ferr0 = n_ferr;
        send(1, 0, 4, SH_W'(0), 10, 10, 1, 10, 10);
        send(0, 0, 4, SH_W'(0), 11, 11, 1, 11, 11);
        for (int k = 0; k < 4; k++)
            send(k == 0, k == 3, 4, SH_W'(0), 20 + k, 30 + k, 1, 20 + k, 30 + k);
        drain();
        check("t5_mid_sop_err", n_ferr - ferr0, 1);

        // Beat without sop in IDLE is dropped
        ferr0 = n_ferr;
        send(0, 0, 4, SH_W'(0), 99, 99, 0, 0, 0);
        drain();
        check("t5_idle_beat_err", n_ferr - ferr0, 1);

        // Single-sample frame, shift 31 clamps to 29
        ferr0 = n_ferr; satv0 = n_satv;
        send(1, 1, 1, SH_W'(31), 536870911, -536870912, 1, 1, -1);
        drain();
        check("t5_single_frame_err", n_ferr - ferr0, 0);
        check("t5_single_satv", n_satv - satv0, 1);

        // Reset in mid-frame, then a clean 12-point frame
        ramp(1200, 600);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ferr0 = n_ferr; satv0 = n_satv;
        ramp(12, 12);
        drain();
        check("t6_frame_err", n_ferr - ferr0, 0);
        check("t6_satv_pulses", n_satv - satv0, 1);
        check("t6_sat_cnt", last_sat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
